// File: rtl/mac_align_pkg.sv
// Shared definitions for the MAC alignment path.
//   EXP_W / PP_W / ALN_W : exponent, denorm partial product and aligned widths
//   SHIFT_LIMIT          : exponent difference at which an aligned term is fully shifted out
//   LD_POS               : bit position of the fraction LSB inside the aligned magnitude
//   term_t               : one buffered partial product {pp, exp}
//   sched_state_t        : group scheduler states
//   umax()               : unsigned exponent maximum
package mac_align_pkg;

    localparam int EXP_W       = 6;
    localparam int PP_W        = 4;
    localparam int ALN_W       = 15;
    localparam int SHIFT_LIMIT = 12;
    localparam int LD_POS      = 11;
    localparam int COST_W      = 51;

    // Fixed cost figure reported by the align unit and forwarded by its users.
    localparam logic [COST_W-1:0] ALIGN_COST = 51'd1487;

    typedef struct packed {
        logic [PP_W-1:0]  pp;
        logic [EXP_W-1:0] exp;
    } term_t;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_ALIGN = 2'd1,
        S_DONE  = 2'd2
    } sched_state_t;

    function automatic logic [EXP_W-1:0] umax(input logic [EXP_W-1:0] a,
                                              input logic [EXP_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/align_CG2_NOclkGating.sv
// Combinational alignment of one denormalised partial product to a group exponent.
//   denorm_pp : {sign, ld, frac[1:0]}
//   exp       : exponent of denorm_pp
//   max_exp   : exponent to align to (never smaller than exp)
//   align_pp  : two's-complement aligned value, magnitude {ld,frac} placed at LD_POS
//               and shifted right by max_exp-exp; zero once the shift reaches SHIFT_LIMIT
//   number    : fixed cost figure of this unit
module align_CG2_NOclkGating
    import mac_align_pkg::*;
(
    input  logic [PP_W-1:0]   denorm_pp,
    input  logic [EXP_W-1:0]  exp,
    input  logic [EXP_W-1:0]  max_exp,
    output logic [ALN_W-1:0]  align_pp,
    output logic [COST_W-1:0] number
);

    logic [EXP_W-1:0] exp_diff;
    logic [ALN_W-2:0] mag;
    logic [ALN_W-2:0] shifted;

    assign exp_diff = max_exp - exp;
    assign mag      = {denorm_pp[PP_W-2:0], {LD_POS{1'b0}}};
    assign shifted  = (exp_diff >= EXP_W'(SHIFT_LIMIT)) ? '0 : (mag >> exp_diff);
    assign align_pp = denorm_pp[PP_W-1] ? -{1'b0, shifted} : {1'b0, shifted};
    assign number   = ALIGN_COST;

endmodule

// File: rtl/align_group_scheduler.sv
// Collects N partial products, finds their maximum exponent, aligns each term
// through one shared align unit and accumulates the signed group sum.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : term handshake, in_pp / in_exp carry the term
//   out_valid/out_ready   : group result handshake
//   out_sum               : signed sum of the N aligned terms (ALN_W+log2(N) bits)
//   out_exp               : group maximum exponent, the scale of out_sum
//   busy                  : a group is partially loaded or being processed
//   number                : cost figure of the shared align unit
module align_group_scheduler
    import mac_align_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PP_W-1:0]            in_pp,
    input  logic [EXP_W-1:0]           in_exp,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ALN_W+$clog2(N)-1:0] out_sum,
    output logic [EXP_W-1:0]           out_exp,
    output logic                       busy,
    output logic [COST_W-1:0]          number
);

    localparam int ACC_W = ALN_W + $clog2(N);
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    sched_state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt, idx;
    logic [EXP_W-1:0] max_exp;
    logic [ACC_W-1:0] acc;
    term_t            grp_buf [N];
    term_t            cur_term;
    logic [ALN_W-1:0] align_pp;
    logic             in_xfer;

    // NOTE: state-holding processes use non-blocking assignments only, so every
    // flop samples the values from before the edge regardless of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_LOAD;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && cnt == LAST) state_nxt = S_ALIGN;
            end
            S_ALIGN: begin
                if (idx == LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_LOAD;
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    assign in_xfer = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            max_exp <= '0;
            acc     <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_xfer) begin
                        max_exp <= (cnt == '0) ? in_exp : umax(max_exp, in_exp);
                        if (cnt == LAST) begin
                            cnt <= '0;
                            idx <= '0;
                            acc <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_ALIGN: begin
                    acc <= acc + {{(ACC_W-ALN_W){align_pp[ALN_W-1]}}, align_pp};
                    idx <= idx + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // NOTE: the group buffer has no reset; every entry is written during LOAD
    // before ALIGN reads it, so its power-up contents are never observed.
    always_ff @(posedge clk) begin
        if (in_xfer) grp_buf[cnt] <= '{pp: in_pp, exp: in_exp};
    end

    assign cur_term = grp_buf[idx];

    align_CG2_NOclkGating u_align (
        .denorm_pp (cur_term.pp),
        .exp       (cur_term.exp),
        .max_exp   (max_exp),
        .align_pp  (align_pp),
        .number    (number)
    );

    assign out_sum = acc;
    assign out_exp = max_exp;
    assign busy    = (state != S_LOAD) || (cnt != '0);

endmodule

// File: tb/tb_align_group_scheduler.sv
module tb_align_group_scheduler;

    localparam int N     = 4;
    localparam int ACC_W = 17;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_pp;
    logic [5:0]       in_exp;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [5:0]       out_exp;
    logic             busy;
    logic [50:0]      number;

    align_group_scheduler #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pp     (in_pp),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_exp   (out_exp),
        .busy      (busy),
        .number    (number)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ACC_W-1:0] sum;
        logic [5:0]       exp;
    } result_t;

    result_t sb[$];
    int      total = 0;
    int      bad   = 0;
    int      cyc   = 0;
    int      last_xfer = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Aligned value of one term: magnitude {ld,frac} weighted by 2^11, divided by
    // 2^(max-exp), zero from a difference of 12 on, negated for a set sign bit.
    function automatic int term_val(input logic [3:0] pp, input logic [5:0] e, input logic [5:0] m);
        int d;
        int mag;
        int v;
        d   = int'(m) - int'(e);
        mag = int'(pp[2:0]);
        if (d >= 12) v = 0;
        else         v = (mag * 2048) / (1 << d);
        return pp[3] ? -v : v;
    endfunction

    task automatic model_push(input logic [15:0] pps, input logic [23:0] exps);
        logic [5:0] m;
        int         s;
        result_t    r;
        m = 6'd0;
        s = 0;
        for (int i = 0; i < N; i++)
            if (exps[i*6 +: 6] > m) m = exps[i*6 +: 6];
        for (int i = 0; i < N; i++)
            s += term_val(pps[i*4 +: 4], exps[i*6 +: 6], m);
        r.sum = s[ACC_W-1:0];
        r.exp = m;
        sb.push_back(r);
    endtask

    task automatic send_term(input logic [3:0] pp, input logic [5:0] e);
        int n;
        in_valid = 1'b1;
        in_pp    = pp;
        in_exp   = e;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        last_xfer = cyc;
        in_valid  = 1'b0;
    endtask

    task automatic send_group(input logic [15:0] pps, input logic [23:0] exps, input bit push);
        if (push) model_push(pps, exps);
        for (int i = 0; i < N; i++) send_term(pps[i*4 +: 4], exps[i*6 +: 6]);
    endtask

    task automatic wait_out(input string tag, output bit ok);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        ok = out_valid;
        if (!ok) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic get_result(input string tag);
        bit      ok;
        result_t r;
        wait_out(tag, ok);
        if (!ok) return;
        check({tag, "_latency"}, 64'(cyc - last_xfer), 64'(N));
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
            return;
        end
        r = sb.pop_front();
        check({tag, "_sum"}, 64'(out_sum), 64'(r.sum));
        check({tag, "_exp"}, 64'(out_exp), 64'(r.exp));
        check({tag, "_in_ready_low"}, 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_out_valid_fall"}, 64'(out_valid), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  64'(in_ready),  64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_sum"},   64'(out_sum),   64'd0);
        check({tag, "_out_exp"},   64'(out_exp),   64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit      ok;
        result_t r;
        logic [15:0] rp;
        logic [23:0] re;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_pp     = 4'd0;
        in_exp    = 6'd0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // equal exponents, all terms at full weight
        send_group({4{4'b0100}}, {6'd10, 6'd10, 6'd10, 6'd10}, 1'b1);
        get_result("t1_equal");

        // decreasing exponents
        send_group({4{4'b0100}}, {6'd3, 6'd8, 6'd9, 6'd10}, 1'b1);
        get_result("t2_spread");

        // mixed signs
        send_group({4'b1110, 4'b0100, 4'b0100, 4'b1100}, {4{6'd5}}, 1'b1);
        get_result("t3_negative");

        // one term exactly SHIFT_LIMIT below the maximum
        send_group({4{4'b0100}}, {6'd20, 6'd20, 6'd8, 6'd20}, 1'b1);
        get_result("t4_limit");

        // zero pp still sets the maximum; difference 11 keeps the smallest step
        send_group({4'b0001, 4'b0111, 4'b0000, 4'b1111}, {6'd33, 6'd40, 6'd44, 6'd43}, 1'b1);
        get_result("t4b_zero_max");

        // back-pressure in DONE, then a term offered during the out transfer
        model_push({4{4'b0100}}, {6'd5, 6'd6, 6'd7, 6'd7});
        send_group({4{4'b0100}}, {6'd5, 6'd6, 6'd7, 6'd7}, 1'b0);
        wait_out("t5_hold", ok);
        if (ok) begin
            r = sb.pop_front();
            for (int i = 0; i < 5; i++) begin
                check("t5_hold_sum",      64'(out_sum),   64'(r.sum));
                check("t5_hold_exp",      64'(out_exp),   64'(r.exp));
                check("t5_hold_in_ready", 64'(in_ready),  64'd0);
                check("t5_hold_valid",    64'(out_valid), 64'd1);
                @(posedge clk); #1;
            end
            in_valid  = 1'b1;
            in_pp     = 4'b0100;
            in_exp    = 6'd9;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check("t5_release_valid",    64'(out_valid), 64'd0);
            check("t5_release_in_ready", 64'(in_ready),  64'd1);
            check("t5_release_not_taken", 64'(busy),     64'd0);
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("t5_term_taken", 64'(busy), 64'd1);
            model_push({4'b0110, 4'b1101, 4'b0100, 4'b0100}, {6'd9, 6'd4, 6'd2, 6'd9});
            send_term(4'b0100, 6'd2);
            send_term(4'b1101, 6'd4);
            send_term(4'b0110, 6'd9);
            get_result("t5_next_group");
        end

        // reset in the middle of ALIGN
        send_group({4'b0111, 4'b1111, 4'b0101, 4'b0110}, {6'd30, 6'd31, 6'd29, 6'd25}, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_mid_reset");
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_group({4'b0101, 4'b0100, 4'b1100, 4'b0111}, {6'd12, 6'd12, 6'd11, 6'd1}, 1'b1);
        get_result("t6_after_reset");

        // random groups
        for (int g = 0; g < 6; g++) begin
            rp = 16'($urandom);
            re = {6'($urandom_range(20, 27)), 6'($urandom_range(20, 27)),
                  6'($urandom_range(0, 63)),  6'($urandom_range(20, 27))};
            send_group(rp, re, 1'b1);
            get_result("rand");
        end

        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
